// File: rtl/sd_cmd_responder_if.sv
// rtl/sd_cmd_responder_if.sv - SD CMD pad and user command/response signals of the CMD responder
interface sd_cmd_responder_if;
    logic        sd_clk;
    logic        sd_cmd_i;
    logic        sd_cmd_o;
    logic        sd_cmd_oe;
    logic        cmd_valid;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        crc_err;
    logic        rsp_ready;
    logic        rsp_valid;
    logic [5:0]  rsp_index;
    logic [31:0] rsp_payload;
    logic        rsp_raw_crc;
    logic        busy;

    modport master (
        output sd_clk, sd_cmd_i, rsp_valid, rsp_index, rsp_payload, rsp_raw_crc,
        input  sd_cmd_o, sd_cmd_oe, cmd_valid, cmd_index, cmd_arg, crc_err, rsp_ready, busy
    );

    modport slave (
        input  sd_clk, sd_cmd_i, rsp_valid, rsp_index, rsp_payload, rsp_raw_crc,
        output sd_cmd_o, sd_cmd_oe, cmd_valid, cmd_index, cmd_arg, crc_err, rsp_ready, busy
    );
endinterface

// File: rtl/sd_cmd_responder.sv
// rtl/sd_cmd_responder.sv - card-side SD CMD line responder: receive 48-bit command, check CRC7, send 48-bit response
module sd_cmd_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int NCR_CYCLES  = 2,
    parameter int RSP_TIMEOUT = 64
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    sd_cmd_responder_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_RX, S_CHECK, S_WAIT, S_TX} state_t;

    localparam logic [7:0] NCR_C = 8'(NCR_CYCLES);
    localparam logic [7:0] TMO_C = 8'(RSP_TIMEOUT);

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:3], c[2] ^ fb, c[1:0], fb};
    endfunction

    function automatic logic [6:0] crc7_40(input logic [39:0] d);
        logic [6:0] c;
        c = '0;
        for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
        return c;
    endfunction

    state_t                 state, state_nx;
    logic [SYNC_STAGES-1:0] clk_sync, cmd_sync;
    logic                   clk_prev;
    logic                   sclk, scmd, rise, fall;
    logic [5:0]             bit_cnt, tx_cnt;
    logic [46:0]            rx_sr;
    logic [6:0]             crc;
    logic [7:0]             rise_cnt;
    logic                   have_rsp;
    logic [47:0]            tx_sr;
    logic                   cmd_o, cmd_oe, valid_q, err_q;
    logic [5:0]             index_q;
    logic [31:0]            arg_q;
    logic                   frame_ok, rsp_ready_c;
    logic [47:0]            rsp_frame;

    // CMD shares the sd_clk chain depth so the sampled bit lines up with the detected rise
    assign sclk = clk_sync[SYNC_STAGES-1];
    assign scmd = cmd_sync[SYNC_STAGES-1];
    assign rise = sclk & ~clk_prev;
    assign fall = ~sclk & clk_prev;

    assign frame_ok    = (crc == rx_sr[7:1]) && rx_sr[0] && rx_sr[46];
    assign rsp_ready_c = (state == S_WAIT) && !have_rsp && (rise_cnt < TMO_C);
    assign rsp_frame   = {2'b00, bus.rsp_index, bus.rsp_payload,
                          bus.rsp_raw_crc ? 7'h7F : crc7_40({2'b00, bus.rsp_index, bus.rsp_payload}),
                          1'b1};

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            clk_sync <= '0;
            cmd_sync <= '1;
            clk_prev <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], bus.sd_clk};
            cmd_sync <= {cmd_sync[SYNC_STAGES-2:0], bus.sd_cmd_i};
            clk_prev <= sclk;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) state <= S_IDLE;
        else                state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (rise && !scmd) state_nx = S_RX;
            S_RX:    if (rise) begin
                         if (bit_cnt == 6'd46 && !scmd) state_nx = S_IDLE;
                         else if (bit_cnt == 6'd0)      state_nx = S_CHECK;
                     end
            S_CHECK: state_nx = frame_ok ? S_WAIT : S_IDLE;
            S_WAIT:  if (have_rsp && rise_cnt >= NCR_C && fall) state_nx = S_TX;
                     else if (!have_rsp && rise_cnt >= TMO_C)   state_nx = S_IDLE;
            S_TX:    if (fall && tx_cnt == 6'd0) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            bit_cnt  <= '0;
            tx_cnt   <= '0;
            rx_sr    <= '0;
            crc      <= '0;
            rise_cnt <= '0;
            have_rsp <= 1'b0;
            tx_sr    <= '0;
            cmd_o    <= 1'b1;
            cmd_oe   <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            index_q  <= '0;
            arg_q    <= '0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                S_IDLE: if (rise && !scmd) begin
                    bit_cnt <= 6'd46;
                    crc     <= '0;
                end
                S_RX: if (rise) begin
                    rx_sr <= {rx_sr[45:0], scmd};
                    if (bit_cnt >= 6'd8) crc <= crc7_step(crc, scmd);
                    if (bit_cnt == 6'd46 && !scmd) err_q <= 1'b1;
                    if (bit_cnt != 6'd0) bit_cnt <= bit_cnt - 6'd1;
                end
                S_CHECK: begin
                    rise_cnt <= '0;
                    have_rsp <= 1'b0;
                    if (frame_ok) begin
                        valid_q <= 1'b1;
                        index_q <= rx_sr[45:40];
                        arg_q   <= rx_sr[39:8];
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (rise && rise_cnt != 8'hFF) rise_cnt <= rise_cnt + 8'd1;
                    if (bus.rsp_valid && rsp_ready_c) begin
                        tx_sr    <= rsp_frame;
                        have_rsp <= 1'b1;
                    end
                    // the start bit goes out on the same fall that enters TX
                    if (state_nx == S_TX) begin
                        cmd_o  <= tx_sr[47];
                        cmd_oe <= 1'b1;
                        tx_sr  <= {tx_sr[46:0], 1'b1};
                        tx_cnt <= 6'd47;
                    end
                end
                S_TX: if (fall) begin
                    if (tx_cnt != 6'd0) begin
                        cmd_o  <= tx_sr[47];
                        tx_sr  <= {tx_sr[46:0], 1'b1};
                        tx_cnt <= tx_cnt - 6'd1;
                    end else begin
                        cmd_o  <= 1'b1;
                        cmd_oe <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sd_cmd_o  = cmd_o;
    assign bus.sd_cmd_oe = cmd_oe;
    assign bus.cmd_valid = valid_q;
    assign bus.crc_err   = err_q;
    assign bus.cmd_index = index_q;
    assign bus.cmd_arg   = arg_q;
    assign bus.rsp_ready = rsp_ready_c;
    assign bus.busy      = (state != S_IDLE);
endmodule
